// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - stage-boundary ctrl/data structs, widths and occupancy states
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } pipe_state_e;

    typedef struct packed {
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
    } idex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
        logic reg_write;
    } exmem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } memwb_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] inme;
        logic [4:0]  wr_reg;
        logic [2:0]  fun3;
        logic [6:0]  fun7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } idex_data_t;

    typedef struct packed {
        logic [31:0] pc_branch;
        logic [31:0] alu_res;
        logic [31:0] reg2;
        logic [4:0]  wr_reg;
        logic        zero;
    } exmem_data_t;

    typedef struct packed {
        logic [31:0] rd_data;
        logic [31:0] alu_res;
        logic [4:0]  wr_reg;
    } memwb_data_t;

    localparam int IDEX_CTRL_W  = $bits(idex_ctrl_t);
    localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);
    localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);
    localparam int IFID_DATA_W  = $bits(ifid_data_t);
    localparam int IDEX_DATA_W  = $bits(idex_data_t);
    localparam int EXMEM_DATA_W = $bits(exmem_data_t);
    localparam int MEMWB_DATA_W = $bits(memwb_data_t);

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// rtl/pipe_stage_buf_slot.sv - one stage register entry: load enable, clear-valid, ctrl zeroed in a bubble
module pipe_slot #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 283
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Payload only moves with a real beat so bubbles keep the last value deterministically.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = valid_i;
            ctrl_d  = valid_i ? ctrl_i : '0;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline stage buffer with handshake, flush and stall counter; PIPE_STAGE_SKID_EN adds a skid slot
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W      = 8,
    parameter int DATA_W      = 283,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    pipe_state_e       state;
    logic              main_load;
    logic              main_vin;
    logic [CTRL_W-1:0] main_cin;
    logic [DATA_W-1:0] main_din;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .load_i  (main_load),
        .valid_i (main_vin),
        .ctrl_i  (main_cin),
        .data_i  (main_din),
        .valid_o (out_valid),
        .ctrl_o  (out_ctrl),
        .data_o  (out_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_load;
    logic              skid_vin;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .load_i  (skid_load),
        .valid_i (skid_vin),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    // Ready depends only on the skid register, cutting the out_ready -> in_ready path.
    assign in_ready = flush || !skid_valid;

    always_comb begin
        state     = skid_valid ? TWO : (out_valid ? ONE : EMPTY);
        main_load = 1'b0;
        main_vin  = 1'b0;
        main_cin  = in_ctrl;
        main_din  = in_data;
        skid_load = 1'b0;
        skid_vin  = 1'b0;
        case (state)
            EMPTY: begin
                main_load = 1'b1;
                main_vin  = in_valid;
            end
            ONE: begin
                if (out_ready) begin
                    main_load = 1'b1;
                    main_vin  = in_valid;
                end else if (in_valid) begin
                    skid_load = 1'b1;
                    skid_vin  = 1'b1;
                end
            end
            TWO: begin
                if (out_ready) begin
                    main_load = 1'b1;
                    main_vin  = 1'b1;
                    main_cin  = skid_ctrl;
                    main_din  = skid_data;
                    skid_load = 1'b1;
                end
            end
            default: ;
        endcase
    end
`else
    assign in_ready = flush || !out_valid || out_ready;

    always_comb begin
        state     = out_valid ? ONE : EMPTY;
        main_load = (state == EMPTY) || out_ready;
        main_vin  = in_valid;
        main_cin  = in_ctrl;
        main_din  = in_data;
    end
`endif

    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed and scoreboard checks for pipe_stage_buf
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ctrl;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [15:0] out_data;
    logic [3:0]  stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(16), .STALL_CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          nxt;
        bit          acc;
        bit          cons;
        logic [15:0] seq;
        logic [23:0] sb_q[$];

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF;
        in_data = 16'h1234; out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_data", out_data, 0);
        chk("rst_stall", stall_cnt, 0);
        rst = 1'b0;
        tick();
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, 16'h1234);
        chk("first_ctrl", out_ctrl, 8'hFF);
        in_valid = 1'b0;
        tick();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_ctrl", out_ctrl, 0);

        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 16'(i); in_ctrl = 8'(i + 1);
            #1;
            chk("stream_rdy", in_ready, 1);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, i);
            chk("stream_ctrl", out_ctrl, i + 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end", out_valid, 0);

        in_valid = 1'b1; in_data = 16'h100; in_ctrl = 8'h11;
        tick();
        chk("bp_a", out_data, 16'h100);
        nxt = 1;
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b0; in_data = 16'(16'h100 + nxt);
            #1;
            acc = in_ready;
            chk("bp_rdy", in_ready, (SKID && c == 0) ? 1 : 0);
            tick();
            if (acc) nxt++;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 16'h100);
        end
        chk("bp_stall5", stall_cnt, 5);
        chk("bp_extra_beats", nxt, SKID ? 2 : 1);
        out_ready = 1'b1; in_data = 16'(16'h100 + nxt);
        #1;
        acc = in_ready;
        chk("bp_release_rdy", in_ready, SKID ? 0 : 1);
        tick();
        if (acc) nxt++;
        chk("bp_b", out_data, 16'h101);
        for (int k = 2; k < 4; k++) begin
            in_data = 16'(16'h100 + nxt);
            #1;
            acc = in_ready;
            tick();
            if (acc) nxt++;
            chk("bp_seq", out_data, 16'h100 + k);
            chk("bp_seq_valid", out_valid, 1);
        end
        chk("bp_stall_hold", stall_cnt, 5);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", out_valid, 0);

        in_valid = 1'b1; in_data = 16'h00D0; in_ctrl = 8'h0D;
        tick();
        chk("fl_d", out_data, 16'h00D0);
        out_ready = 1'b0; in_data = 16'h00E0; in_ctrl = 8'h0E;
        tick();
        chk("fl_stall6", stall_cnt, 6);
        flush = 1'b1; in_data = 16'h00AA; in_ctrl = 8'hFF;
        #1;
        chk("fl_rdy", in_ready, 1);
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_data_held", out_data, 16'h00D0);
        chk("fl_stall_kept", stall_cnt, 6);
        flush = 1'b0; in_data = 16'h00F0; in_ctrl = 8'h0F; out_ready = 1'b1;
        #1;
        chk("fl_after_rdy", in_ready, 1);
        tick();
        chk("fl_f_valid", out_valid, 1);
        chk("fl_f_data", out_data, 16'h00F0);
        chk("fl_f_ctrl", out_ctrl, 8'h0F);
        in_valid = 1'b0;
        tick();
        chk("fl_no_leak", out_valid, 0);

        in_valid = 1'b1; in_data = 16'h0077; in_ctrl = 8'h07;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (9) tick();
        chk("sat_reach", stall_cnt, 15);
        repeat (11) tick();
        chk("sat_hold", stall_cnt, 15);
        chk("sat_data", out_data, 16'h0077);
        chk("sat_valid", out_valid, 1);

        rst = 1'b1;
        tick();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_stall", stall_cnt, 0);
        rst = 1'b0; out_ready = 1'b1;
        tick();

        seq = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = seq;
            in_ctrl  = seq[7:0] ^ 8'h5A;
            chk("rnd_valid", out_valid, (sb_q.size() != 0) ? 1 : 0);
            out_ready = 1'b0;
            #1;
            chk("rnd_rdy0", in_ready, SKID ? (sb_q.size() < 2) : (sb_q.size() == 0));
            out_ready = 1'b1;
            #1;
            chk("rnd_rdy1", in_ready, SKID ? (sb_q.size() < 2) : 1);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons && sb_q.size() != 0) begin
                chk("rnd_order", {out_ctrl, out_data}, sb_q[0]);
                void'(sb_q.pop_front());
            end
            if (acc) begin
                sb_q.push_back({in_ctrl, in_data});
                seq++;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
